// File: rtl/cdc_src_arbiter.sv
// Round-robin arbiter feeding a single registered output slot toward a CDC source half.
// One beat is held until the CDC side accepts it; a new winner reloads the slot on the same edge.
module cdc_src_arbiter #(
   parameter int NumIn     = 4,
   parameter int DataWidth = 32,
   localparam int IdxWidth = $clog2(NumIn)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumIn-1:0]           en_i,
   input  logic [NumIn-1:0]           in_valid_i,
   input  logic [NumIn*DataWidth-1:0] in_data_i,
   output logic [NumIn-1:0]           in_ready_o,
   output logic                       out_valid_o,
   output logic [DataWidth-1:0]       out_data_o,
   output logic [IdxWidth-1:0]        out_idx_o,
   input  logic                       out_ready_i,
   output logic                       busy_o
);

   logic [IdxWidth-1:0]  r_ptr;
   logic                 r_out_valid;
   logic [DataWidth-1:0] r_out_data;
   logic [IdxWidth-1:0]  r_out_idx;

   logic [NumIn-1:0]     w_cand;
   logic [NumIn-1:0]     w_ready;
   logic                 w_slot_free;
   logic                 w_any;
   logic                 w_fire;
   logic [IdxWidth-1:0]  w_win;
   logic [DataWidth-1:0] w_payload [NumIn];

   for (genvar k = 0; k < NumIn; k++) begin : g_unpack
      assign w_payload[k] = in_data_i[k*DataWidth +: DataWidth];
   end

   function automatic logic [IdxWidth-1:0] wrapIdx(input int v);
      int r;
      r = v % NumIn;
      return r[IdxWidth-1:0];
   endfunction

   assign w_cand      = in_valid_i & en_i;
   assign w_slot_free = ~r_out_valid | out_ready_i;

   // Scan from the far end so the nearest candidate after r_ptr is written last and wins.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int off = NumIn; off >= 1; off--) begin
         if (w_cand[wrapIdx(int'(r_ptr) + off)]) begin
            w_win = wrapIdx(int'(r_ptr) + off);
            w_any = 1'b1;
         end
      end
   end

   // Grants are forced low while reset is held, independent of the clock.
   assign w_fire = rst_ni & w_slot_free & w_any;

   always_comb begin
      w_ready = '0;
      for (int k = 0; k < NumIn; k++) begin
         w_ready[k] = w_fire && (w_win == IdxWidth'(k));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr       <= IdxWidth'(NumIn - 1);
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
      end else if (w_fire) begin
         r_ptr       <= w_win;
         r_out_valid <= 1'b1;
         r_out_data  <= w_payload[w_win];
         r_out_idx   <= w_win;
      end else if (r_out_valid && out_ready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready_o  = w_ready;
   assign out_valid_o = r_out_valid;
   assign out_data_o  = r_out_data;
   assign out_idx_o   = r_out_idx;
   assign busy_o      = rst_ni & (r_out_valid | (|w_cand));

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// Self-checking bench for cdc_src_arbiter: a reference arbiter model predicts grants and
// pushes expected beats into a scoreboard queue that is popped on each output handshake.
module tb_cdc_src_arbiter;

   localparam int NumIn     = 4;
   localparam int DataWidth = 32;

   logic                       clk_i;
   logic                       rst_ni;
   logic [NumIn-1:0]           en_i;
   logic [NumIn-1:0]           in_valid_i;
   logic [NumIn*DataWidth-1:0] in_data_i;
   logic [NumIn-1:0]           in_ready_o;
   logic                       out_valid_o;
   logic [DataWidth-1:0]       out_data_o;
   logic [1:0]                 out_idx_o;
   logic                       out_ready_i;
   logic                       busy_o;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] data;
   } beat_t;

   beat_t sb[$];
   int    total = 0;
   int    bad = 0;
   int    mPtr;
   bit    mValid;
   int    reqSeq [NumIn];
   int    expSeq [5] = '{0, 1, 2, 3, 0};

   cdc_src_arbiter #(.NumIn(NumIn), .DataWidth(DataWidth)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] makePayload(input int k);
      logic [7:0] s;
      logic [7:0] kk;
      s  = 8'(reqSeq[k]);
      kk = 8'(k);
      return {16'hCAFE, s, kk};
   endfunction

   // Drive one cycle of inputs at the falling edge, check against the model, then advance.
   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] en, input logic outReady);
      logic [3:0] cand;
      logic [3:0] expReady;
      int         win;
      bit         found;
      beat_t      b;
      in_valid_i  = valid;
      en_i        = en;
      out_ready_i = outReady;
      for (int k = 0; k < NumIn; k++) in_data_i[k*DataWidth +: DataWidth] = makePayload(k);
      #1;
      cand  = valid & en;
      found = 0;
      win   = 0;
      for (int off = 1; off <= NumIn; off++) begin
         if (!found && cand[(mPtr + off) % NumIn]) begin
            found = 1;
            win   = (mPtr + off) % NumIn;
         end
      end
      expReady = 4'b0;
      if (found && (!mValid || outReady)) expReady[win] = 1'b1;
      checkOutput("in_ready", in_ready_o, expReady);
      checkOutput("out_valid", out_valid_o, mValid);
      checkOutput("busy", busy_o, mValid | (|cand));
      if (mValid) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 1, 0);
         end else begin
            checkOutput("out_idx", out_idx_o, sb[0].idx);
            checkOutput("out_data", out_data_o, sb[0].data);
         end
         if (outReady && sb.size() != 0) void'(sb.pop_front());
      end
      if (expReady != 4'b0) begin
         b.idx  = 2'(win);
         b.data = makePayload(win);
         sb.push_back(b);
         reqSeq[win]++;
         mPtr   = win;
         mValid = 1;
      end else if (mValid && outReady) begin
         mValid = 0;
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Reset is dropped away from any clock edge; its effect must be visible at once.
   task automatic doReset();
      in_valid_i  = 4'hF;
      en_i        = 4'hF;
      out_ready_i = 1'b1;
      rst_ni      = 1'b0;
      #1;
      checkOutput("rst_valid", out_valid_o, 0);
      checkOutput("rst_data", out_data_o, 0);
      checkOutput("rst_idx", out_idx_o, 0);
      checkOutput("rst_ready", in_ready_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      mPtr   = NumIn - 1;
      mValid = 0;
      sb.delete();
      for (int k = 0; k < NumIn; k++) reqSeq[k] = 0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni      = 1'b1;
      en_i        = '0;
      in_valid_i  = '0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      for (int k = 0; k < NumIn; k++) reqSeq[k] = 0;
      @(negedge clk_i);
      doReset();

      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'hF, 4'hF, 1'b1);
         checkOutput("seq_idx", out_idx_o, expSeq[i]);
         checkOutput("seq_nobubble", out_valid_o, 1);
      end
      applyStimulus(4'h0, 4'hF, 1'b1);

      doReset();
      applyStimulus(4'b0100, 4'hF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0100, 4'hF, 1'b0);
         checkOutput("bp_data", out_data_o, 32'hCAFE0002);
         checkOutput("bp_idx", out_idx_o, 2);
      end
      applyStimulus(4'h0, 4'hF, 1'b1);

      for (int i = 0; i < 6; i++) applyStimulus(4'hF, 4'b1010, 1'b1);
      applyStimulus(4'hF, 4'b1010, 1'b0);
      applyStimulus(4'hF, 4'b0000, 1'b0);
      applyStimulus(4'h0, 4'b0000, 1'b1);

      doReset();
      applyStimulus(4'b0001, 4'hF, 1'b0);
      applyStimulus(4'b0010, 4'hF, 1'b1);
      checkOutput("simul_idx", out_idx_o, 1);
      checkOutput("simul_valid", out_valid_o, 1);
      applyStimulus(4'h0, 4'hF, 1'b1);

      applyStimulus(4'b0100, 4'hF, 1'b0);
      doReset();
      applyStimulus(4'hF, 4'hF, 1'b1);
      checkOutput("rst_first_grant", out_idx_o, 0);
      applyStimulus(4'h0, 4'hF, 1'b1);

      applyStimulus(4'b1000, 4'hF, 1'b1);
      applyStimulus(4'b0000, 4'hF, 1'b1);
      applyStimulus(4'b1000, 4'hF, 1'b1);
      checkOutput("sparse_idx", out_idx_o, 3);
      applyStimulus(4'hF, 4'hF, 1'b1);
      checkOutput("sparse_ptr", out_idx_o, 0);

      for (int i = 0; i < 300; i++) begin
         logic [3:0] v;
         logic [3:0] e;
         v = 4'($urandom_range(0, 15));
         e = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         applyStimulus(v, e, $urandom_range(0, 3) != 0);
      end

      applyStimulus(4'h0, 4'hF, 1'b1);
      applyStimulus(4'h0, 4'hF, 1'b1);
      checkOutput("drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdc_src_arbiter.md
CDC_SRC_ARBITER -- requirements
Module: cdc_src_arbiter

Interface
- REQ-001: Parameter NumIn, default 4, number of requesters sharing one CDC channel; legal range 2..16.
- REQ-002: Parameter DataWidth, default 32, payload width per requester.
- REQ-003: Derived IdxWidth = $clog2(NumIn), width of the source index.
- REQ-004: clk_i  input  1  source-domain clock; all logic is on the rising edge.
- REQ-005: rst_ni  input  1  asynchronous active-low reset.
- REQ-006: en_i  input  NumIn  per-requester enable mask; a bit at 0 blocks that requester.
- REQ-007: in_valid_i  input  NumIn  per-requester valid.
- REQ-008: in_data_i  input  NumIn*DataWidth  payloads; requester k occupies bits [k*DataWidth +: DataWidth].
- REQ-009: in_ready_o  output  NumIn  per-requester ready; at most one bit is high per cycle.
- REQ-010: out_valid_o  output  1  valid toward the CDC source half.
- REQ-011: out_data_o  output  DataWidth  registered payload.
- REQ-012: out_idx_o  output  IdxWidth  index of the requester that supplied out_data_o.
- REQ-013: out_ready_i  input  1  ready from the CDC source half.
- REQ-014: busy_o  output  1  high while out_valid_o=1 or any enabled requester is valid.

Function
- REQ-015: An input handshake occurs on requester k when in_valid_i[k] & in_ready_o[k] at a rising edge.
- REQ-016: An output handshake occurs when out_valid_o & out_ready_i at a rising edge.
- REQ-017: The output slot is "free" when out_valid_o=0 or an output handshake occurs in the same cycle.
- REQ-018: Candidate set = in_valid_i & en_i; when the slot is free and the set is non-empty, exactly one in_ready_o bit is high: the winner.
- REQ-019: Winner = first candidate scanning ptr+1, ptr+2, ... modulo NumIn; ptr is the last-granted index.
- REQ-020: in_ready_o depends combinationally on state, en_i, in_valid_i and out_ready_i only, never on in_data_i.
- REQ-021: On an input handshake from k: out_data_o <= payload k, out_idx_o <= k, out_valid_o <= 1, ptr <= k, all at the same edge.
- REQ-022: On an output handshake with no simultaneous input handshake: out_valid_o <= 0.
- REQ-023: Simultaneous output and input handshakes reload the slot with no bubble; sustained throughput is 1 beat/cycle.
- REQ-024: Latency: the input handshake at edge N gives out_valid_o=1 from edge N on, visible in cycle N+1.
- REQ-025: While out_valid_o=1 and out_ready_i=0, out_data_o and out_idx_o stay stable and no in_ready_o is asserted.
  - The CDC source half requires stable data.
- REQ-026: ptr changes only on an input handshake; idle cycles and masked requesters never move it.
- REQ-027: Deasserting en_i[k] while beat k sits in the output slot does not cancel that beat.
- REQ-028: Fairness: a requester that stays valid and enabled is granted within NumIn input handshakes.
- REQ-029: All-candidates-empty: no in_ready_o is high; the output state is unchanged apart from REQ-022.

Reset
- REQ-030: While rst_ni=0, the following hold asynchronously:
  - out_valid_o=0, out_data_o='0, out_idx_o=0;
  - ptr=NumIn-1, so requester 0 has first priority after reset;
  - in_ready_o=0, busy_o=0.
- REQ-031: Reset asserted mid-transfer discards the held beat; no partial beat appears after release.
- REQ-032: The first rising edge after rst_ni deasserts may perform a handshake.

Verification
- REQ-033: Bench covers the following directed scenarios, plus a scoreboard checking per-requester order and no loss or duplication.
  - Post-reset: all 4 requesters valid, en_i=4'hF, out_ready_i=1 -> out_idx_o sequence 0,1,2,3,0, with one beat per cycle and no bubbles.
  - Backpressure: req 2 sends 32'hCAFE0002 with out_ready_i=0 for 5 cycles -> out_data_o/out_idx_o stay 32'hCAFE0002/2, and in_ready_o=0 throughout.
  - Mask: en_i=4'b1010, all valid -> grants alternate 1,3,1,3; requesters 0 and 2 never get in_ready_o.
  - Simultaneous: out_valid_o=1 with the slot holding req 0, out_ready_i=1, req 1 valid -> same edge loads req 1; out_valid_o never drops.
  - Reset mid-operation: rst_ni pulsed low while out_valid_o=1 -> out_valid_o=0 immediately; the next grant goes to requester 0.
  - Sparse: only req 3 valid, then only req 3 again -> both granted; ptr stays 3 between them.
